// File: rtl/match_log_pkg.sv
// Shared defaults and types for the match event logger.
package match_log_pkg;

   localparam int unsigned TS_W_DEF  = 16;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned CNT_W_DEF = 8;

   // Detector state in which match_i is asserted
   localparam logic [2:0] DET_FINAL_STATE = 3'b011;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } occ_state_e;

endpackage

// File: rtl/match_event_logger_if.sv
// Host-side timestamp read channel (valid/ready, show-ahead data).
interface match_event_logger_if #(
   parameter int unsigned TS_W = match_log_pkg::TS_W_DEF
) ();
   logic [TS_W-1:0] ts_o;
   logic            ts_valid_o;
   logic            ts_ready_i;

   modport master (output ts_o, output ts_valid_o, input ts_ready_i);
   modport slave  (input ts_o, input ts_valid_o, output ts_ready_i);
endinterface

// File: rtl/match_log_fifo.sv
// Synchronous show-ahead FIFO with occupancy FSM, level and full flags.
module match_log_fifo
   import match_log_pkg::*;
#(
   parameter  int unsigned W     = TS_W_DEF,
   parameter  int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned LW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          valid,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          push_ok_c,
   output logic          drop_c
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   occ_state_e    state_q, state_d;
   logic          pop_ok;

   // A pop frees a slot in the same cycle, so push on FULL with pop is accepted
   assign pop_ok    = pop & (state_q != EMPTY);
   assign push_ok_c = push & ((state_q != FULL) | pop_ok);
   assign drop_c    = push & ~push_ok_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY:   if (push_ok_c) state_d = PARTIAL;
         PARTIAL: begin
            if (push_ok_c && !pop_ok && level_q == LW'(DEPTH - 1))
               state_d = FULL;
            else if (pop_ok && !push_ok_c && level_q == LW'(1))
               state_d = EMPTY;
         end
         FULL:    if (pop_ok && !push_ok_c) state_d = PARTIAL;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok_c) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= PW'(wr_ptr_q + PW'(1));
         end
         if (pop_ok) rd_ptr_q <= PW'(rd_ptr_q + PW'(1));
         level_q <= LW'(level_q + LW'(push_ok_c) - LW'(pop_ok));
      end
   end

   assign valid = (state_q != EMPTY);
   assign full  = (state_q == FULL);
   assign level = level_q;
   assign dout  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/match_event_logger.sv
// Timestamps detector matches into a FIFO read over valid/ready; counts drops.
// MATCH_LOG_COUNT_EN adds a saturating accepted-match counter port.
module match_event_logger
   import match_log_pkg::*;
#(
   parameter  int unsigned TS_W  = TS_W_DEF,
   parameter  int unsigned DEPTH = DEPTH_DEF,
   parameter  int unsigned CNT_W = CNT_W_DEF,
   localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 match_i,
   match_event_logger_if.master rd_if,
   output logic [LW-1:0]        level_o,
   output logic                 full_o,
`ifdef MATCH_LOG_COUNT_EN
   output logic [CNT_W-1:0]     match_cnt_o,
`endif
   output logic [CNT_W-1:0]     drop_cnt_o
);

   logic [TS_W-1:0] ts_q;
   logic            push;
   logic            push_ok_c;
   logic            drop_c;

   assign push = en & match_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  ts_q <= '0;
      else if (en) ts_q <= TS_W'(ts_q + TS_W'(1));
   end

   match_log_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (rd_if.ts_ready_i),
      .din       (ts_q),
      .dout      (rd_if.ts_o),
      .valid     (rd_if.ts_valid_o),
      .level     (level_o),
      .full      (full_o),
      .push_ok_c (push_ok_c),
      .drop_c    (drop_c)
   );

   // Saturating drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          drop_cnt_o <= '0;
      else if (drop_c && drop_cnt_o != '1) drop_cnt_o <= CNT_W'(drop_cnt_o + CNT_W'(1));
   end

`ifdef MATCH_LOG_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              match_cnt_o <= '0;
      else if (push_ok_c && match_cnt_o != '1) match_cnt_o <= CNT_W'(match_cnt_o + CNT_W'(1));
   end
`endif

endmodule
